interval_timer: RTL
===================

# interval_timer

Programmable interval timer built on the structural `incrementer`. It consumes the incrementer's `x_plus_1` output as the next-state value for both a prescaler and a main counter. It supports one-shot and periodic modes and produces a single-cycle expiry pulse for interrupt or sequencing logic downstream. It is the first stateful consumer of the arithmetic library blocks.

## Interface
- `WIDTH`, default 8: main counter and compare width.
- `PRE_WIDTH`, default 4: prescaler counter and divisor width.

Ports:
- `clock`: input, 1. Single clock; all state updates on the rising edge.
- `reset`: input, 1. Synchronous, active-high.
- `start`: input, 1. Latch configuration and begin or restart counting.
- `stop`: input, 1. Halt and return to IDLE.
- `periodic`: input, 1. Mode latched at start. 1 selects auto-reload; 0 selects one-shot.
- `prescale`: input, PRE_WIDTH. Divisor latched at start; tick period is prescale+1 cycles.
- `compare`: input, WIDTH. Terminal count latched at start.
- `count`: output, WIDTH. Current main counter value (registered).
- `running`: output, 1. High in RUNNING.
- `done`: output, 1. High in DONE (one-shot finished).
- `expired`: output, 1. One-cycle pulse per terminal tick.

## Operation
- **States:** IDLE, RUNNING, DONE.
- **Reset:** state=IDLE; `count`=0; prescaler=0; latched prescale, compare and mode are 0; `running`=`done`=`expired`=0.
- **Priority each edge:** reset > stop > start > tick.
- **stop** (any state): state becomes IDLE, `count` holds its value, prescaler becomes 0. A start in the same cycle is ignored.
- **start** (any state, no stop): latch `prescale`, `compare` and `periodic`; `count`=0; prescaler=0; state=RUNNING. This is a restart if already RUNNING or DONE.
- **Prescaler** (RUNNING only): tick = (prescaler == latched prescale).
  - On tick, prescaler becomes 0.
  - Otherwise prescaler becomes its incrementer output.
- **On tick, count ≠ latched compare:** `count` becomes the incrementer output.
- **On tick, count == latched compare:** `expired` is 1 for the following cycle.
  - Periodic: `count`=0, stay in RUNNING.
  - One-shot: `count` holds at compare, state becomes DONE.
- **IDLE and DONE:** counters frozen, no ticks, `expired`=0.
- **Arithmetic:**
  - `count` never exceeds the latched compare, so incrementer wrap is unreachable in the main counter.
  - The prescaler likewise never exceeds the latched prescale.
  - compare=0 expires on every tick. prescale=0 ticks every cycle.
- **Config inputs:** `compare`, `prescale` and `periodic` are sampled only on an accepted start. Changes while RUNNING have no effect.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Let start be accepted at edge E0.
  - First `expired` pulse is high in the cycle after edge E0 + (compare+1)·(prescale+1).
  - Periodic mode repeats every (compare+1)·(prescale+1) cycles thereafter.
- `running` rises in the cycle after E0.
- `done` rises in the same cycle as the one-shot `expired` pulse.
- `expired` is never high for two consecutive cycles unless compare=0 and prescale=0 (periodic), in which case it stays high continuously.
- Reset asserted mid-count: all outputs at reset values the cycle after the reset edge, regardless of pending tick.
- Stop on the terminal-tick edge: stop wins, no `expired` pulse, `count` unchanged.

## Structure
- Package `timer_pkg`: `typedef enum logic [1:0] {IDLE, RUNNING, DONE} timer_state_t`.
- Sub-module: `incrementer`, instantiated twice.
  - WIDTH instance feeds the `count` next-state.
  - PRE_WIDTH instance feeds the prescaler next-state.
- No other arithmetic operators. Equality compares only.
- One next-state always_comb and one always_ff register block.

## Test plan
- **Reset:** assert reset for 2 cycles with start high. Then `count`=0, `running`=0, `done`=0, `expired`=0, state IDLE.
- **One-shot:** compare=3, prescale=0, periodic=0, start at E0. `count` goes 1,2,3. `expired` and `done` high in the cycle after E0+4, `count` holds 3, no further pulses.
- **Periodic with prescale:** compare=2, prescale=1, periodic=1. `expired` pulses every 6 cycles for ≥4 periods; `count` sequence is 0,0,1,1,2,2,0…
- **Stop/start collision:**
  - Stop on the terminal-tick edge gives no `expired`, state IDLE, `count`=compare.
  - Stop and start together give IDLE.
- **Restart and config isolation:**
  - Start while RUNNING at count=5 (compare=9) gives `count`=0 with new compare latched.
  - Changing `compare` mid-run does not alter the expiry time.
- **Boundaries:**
  - WIDTH=8, compare=255, prescale=0, periodic: `count` reaches 255, then 0, with `expired` every 256 cycles.
  - compare=0, prescale=0, periodic: `expired` held high continuously.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg
// Shared types and constants for the interval timer.
//   timer_state_t : controller state (IDLE, RUNNING, DONE)
//   TIMER_WIDTH_DEFAULT / TIMER_PRE_WIDTH_DEFAULT : default widths
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } timer_state_t;

  localparam int TIMER_WIDTH_DEFAULT     = 8;
  localparam int TIMER_PRE_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/incrementer.sv
// incrementer
// Structural +1 built from a ripple chain of half adders.
// Ports:
//   x        : input  [WIDTH-1:0]  operand
//   x_plus_1 : output [WIDTH-1:0]  x + 1, modulo 2**WIDTH (carry out dropped)
module incrementer #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] x_plus_1
);

  // carry[gi] is the carry into bit gi; the injected +1 is carry[0].
  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_half_adder
      assign x_plus_1[gi] = x[gi] ^ carry[gi];
      // The carry out of the top bit is never consumed, so it is not built.
      if (gi < WIDTH - 1) begin : g_carry
        assign carry[gi+1] = x[gi] & carry[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/interval_timer.sv
// interval_timer
// Programmable interval timer: a prescaler divides the clock into ticks and a
// main counter counts ticks up to a latched terminal value. One-shot mode
// stops in DONE at the terminal tick; periodic mode reloads to zero.
// Ports:
//   clock    : input            rising-edge clock
//   reset    : input            synchronous, active-high reset
//   start    : input            latch configuration and (re)start counting
//   stop     : input            halt and return to IDLE (beats start)
//   periodic : input            1 = auto-reload, 0 = one-shot (latched at start)
//   prescale : input  [PRE_WIDTH-1:0]  tick period is prescale+1 cycles
//   compare  : input  [WIDTH-1:0]      terminal count (latched at start)
//   count    : output [WIDTH-1:0]      current main counter value
//   running  : output           high while RUNNING
//   done     : output           high while DONE
//   expired  : output           one-cycle pulse per terminal tick
module interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = TIMER_WIDTH_DEFAULT,
  parameter int PRE_WIDTH = TIMER_PRE_WIDTH_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 periodic,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]     compare,
  output logic [WIDTH-1:0]     count,
  output logic                 running,
  output logic                 done,
  output logic                 expired
);

  // Architectural state
  timer_state_t         state_reg,    state_next;
  logic [WIDTH-1:0]     count_reg,    count_next;
  logic [PRE_WIDTH-1:0] pre_reg,      pre_next;
  logic [PRE_WIDTH-1:0] pre_lim_reg,  pre_lim_next;
  logic [WIDTH-1:0]     cmp_reg,      cmp_next;
  logic                 per_reg,      per_next;

  // Registered outputs
  logic                 running_reg,  running_next;
  logic                 done_reg,     done_next;
  logic                 expired_reg,  expired_next;

  // Incrementer results used as next-state values
  logic [WIDTH-1:0]     count_inc;
  logic [PRE_WIDTH-1:0] pre_inc;

  logic                 tick;
  logic                 terminal;

  incrementer #(
    .WIDTH (WIDTH)
  ) u_count_inc (
    .x        (count_reg),
    .x_plus_1 (count_inc)
  );

  incrementer #(
    .WIDTH (PRE_WIDTH)
  ) u_pre_inc (
    .x        (pre_reg),
    .x_plus_1 (pre_inc)
  );

  // Next-state logic. Priority: stop > start > tick (reset handled in the
  // register block). Counters never exceed their latched limits, so the
  // incrementer wrap-around is never selected.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pre_next     = pre_reg;
    pre_lim_next = pre_lim_reg;
    cmp_next     = cmp_reg;
    per_next     = per_reg;
    expired_next = 1'b0;
    tick         = 1'b0;
    terminal     = 1'b0;

    if (stop) begin
      // Count is left as-is so software can read where it stopped.
      state_next = IDLE;
      pre_next   = '0;
    end else if (start) begin
      pre_lim_next = prescale;
      cmp_next     = compare;
      per_next     = periodic;
      count_next   = '0;
      pre_next     = '0;
      state_next   = RUNNING;
    end else if (state_reg == RUNNING) begin
      tick = (pre_reg == pre_lim_reg);
      if (tick) begin
        pre_next = '0;
        terminal = (count_reg == cmp_reg);
        if (terminal) begin
          expired_next = 1'b1;
          if (per_reg) begin
            count_next = '0;
          end else begin
            // One-shot: count parks at compare.
            state_next = DONE;
          end
        end else begin
          count_next = count_inc;
        end
      end else begin
        pre_next = pre_inc;
      end
    end

    // Status outputs track the state being entered so they line up with it.
    running_next = (state_next == RUNNING);
    done_next    = (state_next == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      pre_reg     <= '0;
      pre_lim_reg <= '0;
      cmp_reg     <= '0;
      per_reg     <= 1'b0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      pre_reg     <= pre_next;
      pre_lim_reg <= pre_lim_next;
      cmp_reg     <= cmp_next;
      per_reg     <= per_next;
      running_reg <= running_next;
      done_reg    <= done_next;
      expired_reg <= expired_next;
    end
  end

  assign count   = count_reg;
  assign running = running_reg;
  assign done    = done_reg;
  assign expired = expired_reg;

endmodule
